rr_arb8: RTL and testbench

RR_ARB8 -- requirements
Module: rr_arb8

---
 rtl/rr_arb8.sv | 100 ++++++++++
 tb/tb_rr_arb8.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/rr_arb8.sv
// rr_arb8: 8-way round-robin arbiter with a registered output slot and accepted-beat counter.
// Define RR_ARB8_LOCK_EN to add the req_lock port and the IDLE/LOCKED ownership FSM.
module rr_arb8 #(
    parameter int NREQ = 8,
    parameter int DW   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*DW-1:0] req_data,
`ifdef RR_ARB8_LOCK_EN
    input  logic [NREQ-1:0]   req_lock,
`endif
    output logic [NREQ-1:0]   req_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data,
    output logic [2:0]        out_id,
    output logic [15:0]       beat_cnt
);
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [2:0]      out_id_q, out_id_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [15:0]     beat_cnt_q, beat_cnt_d;
    logic [NREQ-1:0] elig;
    logic [2:0]      win, idx;
    logic            found, slot_free, grant;
`ifdef RR_ARB8_LOCK_EN
    typedef enum logic {IDLE, LOCKED} lock_t;
    lock_t      lock_q, lock_d;
    logic [2:0] owner_q, owner_d;
`endif

    always_comb begin
`ifdef RR_ARB8_LOCK_EN
        elig = (lock_q == LOCKED) ? (req_valid & ({{(NREQ-1){1'b0}}, 1'b1} << owner_q)) : req_valid;
`else
        elig = req_valid;
`endif
        win   = '0;
        idx   = '0;
        found = 1'b0;
        // Scan from the far end so the closest requester to ptr is the last to overwrite win.
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = ptr_q + 3'(k);
            if (elig[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        slot_free   = !out_valid_q || out_ready;
        grant       = rst_n && slot_free && found;
        req_ready   = grant ? ({{(NREQ-1){1'b0}}, 1'b1} << win) : '0;
        out_valid_d = slot_free ? grant : out_valid_q;
        out_data_d  = grant ? req_data[win*DW +: DW] : out_data_q;
        out_id_d    = grant ? win : out_id_q;
        ptr_d       = grant ? win + 3'd1 : ptr_q;
        beat_cnt_d  = beat_cnt_q + 16'(grant);
`ifdef RR_ARB8_LOCK_EN
        lock_d  = lock_q;
        owner_d = owner_q;
        if (grant && lock_q == IDLE && req_lock[win]) begin
            lock_d  = LOCKED;
            owner_d = win;
        end else if (grant && lock_q == LOCKED && !req_lock[win]) begin
            lock_d = IDLE;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            ptr_q       <= '0;
            beat_cnt_q  <= '0;
`ifdef RR_ARB8_LOCK_EN
            lock_q      <= IDLE;
            owner_q     <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            ptr_q       <= ptr_d;
            beat_cnt_q  <= beat_cnt_d;
`ifdef RR_ARB8_LOCK_EN
            lock_q      <= lock_d;
            owner_q     <= owner_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign beat_cnt  = beat_cnt_q;
endmodule

// File: tb/tb_rr_arb8.sv
// tb_rr_arb8: directed self-checking bench for rr_arb8.
module tb_rr_arb8;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   req_valid = '0;
    logic [127:0] req_data = '0;
    logic [7:0]   req_lock = '0;
    logic [7:0]   req_ready;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [15:0]  out_data;
    logic [2:0]   out_id;
    logic [15:0]  beat_cnt;
    int           n_chk = 0;
    int           n_fail = 0;

    rr_arb8 dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
`ifdef RR_ARB8_LOCK_EN
        .req_lock(req_lock),
`endif
        .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 8'hFF;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) req_data[i*16 +: 16] = 16'h1000 + 16'(i);
        step();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_chk++; if (out_data !== 16'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0000", out_data); end
        n_chk++; if (out_id !== 3'd0) begin n_fail++; $display("FAIL reset_out_id got %0d want 0", out_id); end
        n_chk++; if (beat_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_beat_cnt got %h want 0000", beat_cnt); end
        n_chk++; if (req_ready !== 8'h00) begin n_fail++; $display("FAIL reset_req_ready got %h want 00", req_ready); end
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_rr_all();
        for (int i = 0; i < 8; i++) begin
            n_chk++; if (req_ready !== 8'(1 << i)) begin n_fail++; $display("FAIL rr_all_ready[%0d] got %h want %h", i, req_ready, 8'(1 << i)); end
            step();
            n_chk++; if (out_valid !== 1'b1 || out_id !== 3'(i) || out_data !== 16'h1000 + 16'(i))
                begin n_fail++; $display("FAIL rr_all_out[%0d] got v=%b id=%0d d=%h want v=1 id=%0d d=%h", i, out_valid, out_id, out_data, i, 16'h1000 + 16'(i)); end
        end
        n_chk++; if (beat_cnt !== 16'd8) begin n_fail++; $display("FAIL rr_all_beat_cnt got %0d want 8", beat_cnt); end
        req_valid = 8'h00;
        step();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_two_req();
        logic [2:0] exp_id [4] = '{3'd0, 3'd7, 3'd0, 3'd7};
        req_valid = 8'h81;
        for (int i = 0; i < 4; i++) begin
            step();
            n_chk++; if (out_id !== exp_id[i] || out_valid !== 1'b1)
                begin n_fail++; $display("FAIL two_req[%0d] got id=%0d v=%b want id=%0d v=1", i, out_id, out_valid, exp_id[i]); end
        end
        n_chk++; if (beat_cnt !== 16'd12) begin n_fail++; $display("FAIL two_req_beat_cnt got %0d want 12", beat_cnt); end
    endtask

    task automatic test_stall();
        req_valid = 8'h08;
        req_data[3*16 +: 16] = 16'hA5A5;
        step();
        out_ready = 1'b0;
        req_data[3*16 +: 16] = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_chk++; if (req_ready !== 8'h00) begin n_fail++; $display("FAIL stall_ready[%0d] got %h want 00", i, req_ready); end
            step();
            n_chk++; if (out_valid !== 1'b1 || out_id !== 3'd3 || out_data !== 16'hA5A5)
                begin n_fail++; $display("FAIL stall_hold[%0d] got v=%b id=%0d d=%h want v=1 id=3 d=a5a5", i, out_valid, out_id, out_data); end
        end
        out_ready = 1'b1;
        #1;
        n_chk++; if (req_ready !== 8'h08) begin n_fail++; $display("FAIL stall_release_ready got %h want 08", req_ready); end
        step();
        n_chk++; if (out_data !== 16'h1234 || out_id !== 3'd3) begin n_fail++; $display("FAIL stall_next got id=%0d d=%h want id=3 d=1234", out_id, out_data); end
        n_chk++; if (beat_cnt !== 16'd14) begin n_fail++; $display("FAIL stall_beat_cnt got %0d want 14", beat_cnt); end
        req_valid = 8'h00;
        step();
    endtask

    task automatic test_async_reset();
        req_valid = 8'h01;
        step();
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre got v=%b want 1", out_valid); end
        req_valid = 8'h00;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_async got v=%b want 0", out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 8'h10;
        #1;
        n_chk++; if (req_ready !== 8'h10) begin n_fail++; $display("FAIL areset_ready got %h want 10", req_ready); end
        step();
        n_chk++; if (out_id !== 3'd4 || out_valid !== 1'b1) begin n_fail++; $display("FAIL areset_grant got id=%0d v=%b want id=4 v=1", out_id, out_valid); end
        out_ready = 1'b1;
        req_valid = 8'hFF;
        #1;
        n_chk++; if (req_ready !== 8'h20) begin n_fail++; $display("FAIL areset_ptr got ready=%h want 20", req_ready); end
        req_valid = 8'h00;
        step();
    endtask

`ifdef RR_ARB8_LOCK_EN
    task automatic test_lock();
        logic [2:0] exp_id [4] = '{3'd2, 3'd2, 3'd2, 3'd3};
        do_reset();
        out_ready = 1'b1;
        req_valid = 8'h04;
        req_lock  = 8'h04;
        step();
        n_chk++; if (out_id !== exp_id[0]) begin n_fail++; $display("FAIL lock[0] got id=%0d want 2", out_id); end
        req_valid = 8'hFF;
        for (int i = 1; i < 4; i++) begin
            req_lock = (i == 1) ? 8'h04 : 8'h00;
            step();
            n_chk++; if (out_id !== exp_id[i]) begin n_fail++; $display("FAIL lock[%0d] got id=%0d want %0d", i, out_id, exp_id[i]); end
        end
        req_valid = 8'h00;
        step();
    endtask
`endif

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        req_valid = 8'hFF;
        repeat (65535) @(posedge clk);
        #1;
        n_chk++; if (beat_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_pre got %h want ffff", beat_cnt); end
        step();
        n_chk++; if (beat_cnt !== 16'h0000) begin n_fail++; $display("FAIL wrap_post got %h want 0000", beat_cnt); end
        req_valid = 8'h00;
    endtask

    initial begin
        test_reset();
        test_rr_all();
        test_two_req();
        test_stall();
        test_async_reset();
`ifdef RR_ARB8_LOCK_EN
        test_lock();
`endif
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
